// File: rtl/sodor_ctrl_pkg.sv
// Shared control definitions for the Sodor multi-cycle sequencer: opcodes, FSM states,
// ALU function encoding and branch funct3 codes.
package sodor_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StDecode,
    StRead,
    StExec,
    StWb
  } state_e;

  typedef enum logic [1:0] {
    KindR,
    KindI,
    KindB,
    KindIllegal
  } kind_e;

  // alu_fn = {alt, funct3}; alt selects SUB / SRA.
  typedef struct packed {
    logic       alt;
    logic [2:0] op;
  } alu_fn_t;

  localparam logic [2:0] F3_SR   = 3'd5;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  function automatic kind_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_R:   return KindR;
      OPC_I:   return KindI;
      OPC_B:   return KindB;
      default: return KindIllegal;
    endcase
  endfunction

endpackage

// File: rtl/sodor_imm_gen.sv
// Combinational I-type and B-type immediate extraction from an RV32I instruction word.
module sodor_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_b
);

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  // rs1/funct3 and opcode fields carry no immediate bits for I/B formats.
  logic unused_bits;
  assign unused_bits = ^{inst[19:12], inst[6:0]};

endmodule

// File: rtl/sodor_mc_sequencer.sv
// Multi-cycle RV32I control sequencer (R/I ALU ops and conditional branches): owns the PC,
// fetches over valid/ready and drives an external register file and ALU.
module sodor_mc_sequencer
  import sodor_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_y,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            illegal
);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_b;
  logic            br_taken;
  alu_fn_t         fn;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  sodor_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst  (ir_q),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  // ir_q[30] is funct7[5] for R-type and imm[10] for I-type shifts.
  always_comb begin
    fn.op  = funct3;
    fn.alt = 1'b0;
    if (kind_q == KindR) begin
      fn.alt = ir_q[30];
    end else if (kind_q == KindI && funct3 == F3_SR) begin
      fn.alt = ir_q[30];
    end
  end

  assign alu_fn    = fn;
  assign alu_a     = rs1_q;
  assign alu_b     = (kind_q == KindI) ? imm_i : rs2_q;
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign rf_waddr  = rd;
  assign rf_wdata  = result_q;
  assign pc        = pc_q;
  assign imem_req_addr = pc_q;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_q == rs2_q);
      F3_BNE:  br_taken = (rs1_q != rs2_q);
      F3_BLT:  br_taken = ($signed(rs1_q) < $signed(rs2_q));
      F3_BGE:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: br_taken = (rs1_q < rs2_q);
      F3_BGEU: br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    ir_d           = ir_q;
    pc_d           = pc_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    result_d       = result_q;
    taken_d        = taken_q;
    imem_req_valid = 1'b0;
    rf_wen         = 1'b0;
    retire         = 1'b0;
    illegal        = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_resp_valid) begin
          ir_d    = imem_resp_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        kind_d  = classify(opcode);
        state_d = StRead;
      end
      StRead: begin
        rs1_d   = rf_rdata1;
        rs2_d   = rf_rdata2;
        state_d = StExec;
      end
      StExec: begin
        result_d = alu_y;
        taken_d  = br_taken;
        state_d  = StWb;
      end
      StWb: begin
        state_d = StFetch;
        pc_d    = pc_q + XLEN'(4);
        unique case (kind_q)
          KindR, KindI: begin
            rf_wen = (rd != 5'd0);
            retire = 1'b1;
          end
          KindB: begin
            retire = 1'b1;
            if (taken_q) pc_d = pc_q + imm_b;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: state_d = StFetch;
    endcase

    // Reset suppresses every side effect in the same cycle, including a WB commit.
    if (reset) begin
      imem_req_valid = 1'b0;
      rf_wen         = 1'b0;
      retire         = 1'b0;
      illegal        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      kind_q   <= KindIllegal;
      ir_q     <= '0;
      pc_q     <= RESET_PC;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      taken_q  <= taken_d;
    end
  end

endmodule

// File: tb/tb_sodor_mc_sequencer.sv
// Directed bench for sodor_mc_sequencer with a behavioural register file, ALU and
// instruction-memory handshake driven step by step.
module tb_sodor_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_fn;
  logic [31:0] alu_y;
  logic [31:0] pc;
  logic        retire;
  logic        illegal;

  int          n_tests;
  int          n_fail;
  logic        rf_clr;
  logic [31:0] rf_mem [32];
  logic [3:0]  fn_seen;

  always #5 clk = ~clk;

  sodor_mc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_fn          (alu_fn),
    .alu_y           (alu_y),
    .pc              (pc),
    .retire          (retire),
    .illegal         (illegal)
  );

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_wen && rf_waddr != 5'd0) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  always_comb begin
    rf_rdata1 = rf_mem[rf_raddr1];
    rf_rdata2 = rf_mem[rf_raddr2];
  end

  always_comb begin
    case (alu_fn)
      4'h8:    alu_y = alu_a - alu_b;
      4'h4:    alu_y = alu_a ^ alu_b;
      4'h5:    alu_y = alu_a >> alu_b[4:0];
      4'hD:    alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'h6:    alu_y = alu_a | alu_b;
      4'h7:    alu_y = alu_a & alu_b;
      default: alu_y = alu_a + alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered during a FETCH cycle; returns after the WB-following FETCH cycle has begun.
  task automatic step_instr(input string tag, input logic [31:0] inst, input int rdy_wait,
                            input int rsp_wait, input logic [31:0] pc_now,
                            input int exp_cyc, input logic exp_wen, input logic [4:0] exp_waddr,
                            input logic [31:0] exp_wdata, input logic exp_retire,
                            input logic exp_illegal, input logic [31:0] exp_next);
    int cyc;
    cyc = 1;
    for (int i = 0; i < rdy_wait; i++) begin
      imem_req_ready = 1'b0;
      #1;
      chk({tag, "_wait_valid"}, 32'(imem_req_valid), 32'd1);
      chk({tag, "_wait_addr"}, imem_req_addr, pc_now);
      tick();
      cyc++;
    end
    imem_req_ready = 1'b1;
    #1;
    chk({tag, "_req_addr"}, imem_req_addr, pc_now);
    tick();
    imem_req_ready = 1'b0;
    cyc++;
    for (int i = 0; i < rsp_wait; i++) begin
      tick();
      cyc++;
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = inst;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    cyc++;
    for (int k = 0; k < 12 && !(retire || illegal); k++) begin
      fn_seen = alu_fn;
      tick();
      cyc++;
    end
    chk({tag, "_wb_reached"}, 32'(retire | illegal), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_wen"}, 32'(rf_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(exp_waddr));
      chk({tag, "_wdata"}, rf_wdata, exp_wdata);
    end
    chk({tag, "_retire"}, 32'(retire), 32'(exp_retire));
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_illegal));
    tick();
    chk({tag, "_next_pc"}, pc, exp_next);
    chk({tag, "_next_addr"}, imem_req_addr, exp_next);
    chk({tag, "_next_valid"}, 32'(imem_req_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    fn_seen         = '0;
    reset           = 1'b1;
    rf_clr          = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_pc", pc, 32'h0);
    reset  = 1'b0;
    rf_clr = 1'b0;
    #1;
    chk("first_valid", 32'(imem_req_valid), 32'd1);

    step_instr("addi_x1_5", 32'h00500093, 0, 0, 32'h00, 6, 1'b1, 5'd1, 32'd5, 1'b1, 1'b0, 32'h04);
    step_instr("addi_x1_2", 32'h00208093, 0, 0, 32'h04, 6, 1'b1, 5'd1, 32'd7, 1'b1, 1'b0, 32'h08);
    step_instr("addi_x2_m1", 32'hFFF00113, 0, 0, 32'h08, 6, 1'b1, 5'd2, 32'hFFFFFFFF, 1'b1,
               1'b0, 32'h0C);
    step_instr("add_x3", 32'h002081B3, 0, 0, 32'h0C, 6, 1'b1, 5'd3, 32'd6, 1'b1, 1'b0, 32'h10);
    chk("add_fn", 32'(fn_seen), 32'h0);
    step_instr("bne_eq", 32'h00109463, 0, 0, 32'h10, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h14);
    step_instr("sub_x4", 32'h40208233, 0, 0, 32'h14, 6, 1'b1, 5'd4, 32'd8, 1'b1, 1'b0, 32'h18);
    chk("sub_fn", 32'(fn_seen), 32'h8);
    step_instr("addi_x5_1", 32'h00100293, 0, 0, 32'h18, 6, 1'b1, 5'd5, 32'd1, 1'b1, 1'b0, 32'h1C);
    step_instr("blt_taken", 32'h00514863, 0, 0, 32'h1C, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h2C);
    step_instr("bltu_not", 32'h00516863, 0, 0, 32'h2C, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h30);
    step_instr("addi_x0", 32'h00100013, 0, 0, 32'h30, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h34);
    step_instr("lui_illegal", 32'h123452B7, 0, 0, 32'h34, 6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1,
               32'h38);
    chk("lui_no_write_x5", rf_mem[5], 32'd1);
    step_instr("srai_x8", 32'h40415413, 0, 0, 32'h38, 6, 1'b1, 5'd8, 32'hFFFFFFFF, 1'b1, 1'b0,
               32'h3C);
    chk("srai_fn", 32'(fn_seen), 32'hD);
    step_instr("beq_back", 32'hFC000AE3, 0, 0, 32'h3C, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h10);
    step_instr("beq_m8", 32'hFE000CE3, 0, 0, 32'h10, 6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h08);
    step_instr("stall_addi", 32'h00300313, 3, 2, 32'h08, 11, 1'b1, 5'd6, 32'd3, 1'b1, 1'b0,
               32'h0C);
    chk("rf_x3", rf_mem[3], 32'd6);
    chk("rf_x4", rf_mem[4], 32'd8);

    // addi x7,x0,9 interrupted by reset while in EXEC.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00900393;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_exec_wen", 32'(rf_wen), 32'd0);
    chk("rst_exec_retire", 32'(retire), 32'd0);
    chk("rst_exec_valid", 32'(imem_req_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_exec_addr", imem_req_addr, 32'h0);
    chk("rst_exec_pc", pc, 32'h0);
    chk("rst_exec_fetch", 32'(imem_req_valid), 32'd1);
    step_instr("post_rst", 32'h00500093, 0, 0, 32'h00, 6, 1'b1, 5'd1, 32'd5, 1'b1, 1'b0, 32'h04);
    chk("rst_exec_x7", rf_mem[7], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
